aes_round_ctrl: RTL and testbench



---
 rtl/aes_pkg.sv | 43 ++++
 rtl/aes_round_ctrl.sv | 128 ++++++++++++
 tb/tb_aes_round_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types and helpers.
//   aes_block_t       : 128-bit block as it travels over the block interfaces.
//   aes_state_t       : 4x4 byte matrix indexed [row][col], as seen by the diffusion datapath.
//   aes_unpack/aes_pack : conversions between the two. Byte n of the block
//                       (byte 0 = bits 127:120) maps to row n%4, column n/4.
//   AES128_ROUNDS     : round count for a 128-bit key.
//   aes_ctrl_state_e  : round sequencer FSM states.
package aes_pkg;

  typedef logic [127:0] aes_block_t;
  typedef logic [3:0][3:0][7:0] aes_state_t;

  localparam int AES128_ROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    KEY0  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } aes_ctrl_state_e;

  function automatic aes_state_t aes_unpack(input aes_block_t blk);
    aes_state_t s;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        s[r][c] = blk[127 - 8 * (r + 4 * c) -: 8];
      end
    end
    return s;
  endfunction

  function automatic aes_block_t aes_pack(input aes_state_t s);
    aes_block_t blk;
    blk = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        blk[127 - 8 * (r + 4 * c) -: 8] = s[r][c];
      end
    end
    return blk;
  endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES-128 round sequencer. Owns the cipher state register,
// fetches one round key per round and applies AddRoundKey itself; the
// confusion/diffusion datapath is external and purely combinational.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready/in_block plaintext handshake (accepted only in IDLE)
//   key_req_valid/key_req_round round-key request; key_valid/key_in answer it
//   dp_state/dp_final          state and last-round flag to the round datapath
//   dp_result                  combinational datapath result
//   out_valid/out_ready/out_block ciphertext handshake
//   busy                       high whenever the FSM is not IDLE
//   abort                      only with AES_ROUND_CTRL_ABORT_EN defined:
//                              drops the in-flight block and returns to IDLE
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic        abort,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  aes_block_t  in_block,
  output logic        key_req_valid,
  output logic [3:0]  key_req_round,
  input  logic        key_valid,
  input  aes_block_t  key_in,
  output aes_block_t  dp_state,
  output logic        dp_final,
  input  aes_block_t  dp_result,
  output logic        out_valid,
  input  logic        out_ready,
  output aes_block_t  out_block,
  output logic        busy
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  aes_ctrl_state_e fsm_q, fsm_d;
  aes_block_t      state_q, state_d;
  logic [3:0]      rnd_q, rnd_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
    end
  end

  // Without a key beat the KEY0/ROUND branches leave everything untouched,
  // so a stalled key schedule simply freezes the sequencer.
  always_comb begin
    fsm_d         = fsm_q;
    state_d       = state_q;
    rnd_d         = rnd_q;
    in_ready      = 1'b0;
    key_req_valid = 1'b0;
    key_req_round = 4'd0;
    dp_final      = 1'b0;
    out_valid     = 1'b0;
    busy          = 1'b1;

    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_d = in_block;
          rnd_d   = 4'd0;
          fsm_d   = KEY0;
        end
      end
      KEY0: begin
        key_req_valid = 1'b1;
        key_req_round = 4'd0;
        if (key_valid) begin
          state_d = state_q ^ key_in;
          rnd_d   = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        key_req_valid = 1'b1;
        key_req_round = rnd_q;
        dp_final      = (rnd_q == LAST_RND);
        if (key_valid) begin
          state_d = dp_result ^ key_in;
          if (rnd_q == LAST_RND) begin
            fsm_d = DONE;
          end else begin
            rnd_d = rnd_q + 4'd1;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase

`ifdef AES_ROUND_CTRL_ABORT_EN
    // Abort overrides any key beat or output handshake in the same cycle.
    if (abort && (fsm_q != IDLE)) begin
      fsm_d   = IDLE;
      state_d = '0;
      rnd_d   = 4'd0;
    end
`endif
  end

  assign dp_state  = state_q;
  assign out_block = state_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: directed bench for aes_round_ctrl. Supplies a reference
// AES round datapath and key schedule, and checks against FIPS-197 vectors.
// With AES_ROUND_CTRL_ABORT_EN defined it also exercises the abort port.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  localparam int NR = AES128_ROUNDS;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  aes_block_t  in_block;
  logic        key_req_valid;
  logic [3:0]  key_req_round;
  logic        key_valid;
  aes_block_t  key_in;
  aes_block_t  dp_state;
  logic        dp_final;
  aes_block_t  dp_result;
  logic        out_valid;
  logic        out_ready;
  aes_block_t  out_block;
  logic        busy;
`ifdef AES_ROUND_CTRL_ABORT_EN
  logic        abort;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  aes_block_t rk [0:NR];

  localparam aes_block_t PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam aes_block_t KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam aes_block_t CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam aes_block_t PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam aes_block_t KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam aes_block_t CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_round_ctrl #(.NUM_ROUNDS(NR)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort         (abort),
`endif
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_block      (in_block),
    .key_req_valid (key_req_valid),
    .key_req_round (key_req_round),
    .key_valid     (key_valid),
    .key_in        (key_in),
    .dp_state      (dp_state),
    .dp_final      (dp_final),
    .dp_result     (dp_result),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_block     (out_block),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference GF(2^8) arithmetic and S-box (multiplicative inverse + affine).
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv  = 8'h01;
    logic [7:0] base = x;
    logic [7:0] e    = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // External round datapath: SubBytes, ShiftRows, MixColumns unless final.
  function automatic aes_block_t round_fn(input aes_block_t blk, input logic fin);
    aes_state_t s = aes_unpack(blk);
    aes_state_t t;
    aes_state_t u;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r][c] = sbox(s[r][(c + r) % 4]);
    if (fin) return aes_pack(t);
    for (int c = 0; c < 4; c++) begin
      u[0][c] = xtime(t[0][c]) ^ xtime(t[1][c]) ^ t[1][c] ^ t[2][c] ^ t[3][c];
      u[1][c] = t[0][c] ^ xtime(t[1][c]) ^ xtime(t[2][c]) ^ t[2][c] ^ t[3][c];
      u[2][c] = t[0][c] ^ t[1][c] ^ xtime(t[2][c]) ^ xtime(t[3][c]) ^ t[3][c];
      u[3][c] = xtime(t[0][c]) ^ t[0][c] ^ t[1][c] ^ t[2][c] ^ xtime(t[3][c]);
    end
    return aes_pack(u);
  endfunction

  assign dp_result = round_fn(dp_state, dp_final);

  task automatic expand_key(input aes_block_t key);
    logic [31:0] w [0:4*NR+3];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 4 * NR + 4; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k <= NR; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, " in_ready"},      in_ready,      1);
    check_output({tag, " key_req_valid"}, key_req_valid, 0);
    check_output({tag, " key_req_round"}, key_req_round, 0);
    check_output({tag, " dp_final"},      dp_final,      0);
    check_output({tag, " out_valid"},     out_valid,     0);
    check_output({tag, " busy"},          busy,          0);
    check_output({tag, " dp_state"},      dp_state,      0);
    check_output({tag, " out_block"},     out_block,     0);
  endtask

  // Runs from the KEY0 cycle (cycle 1 after accept). Each key beat is
  // preceded by 'stall' cycles of key_valid low. Returns early at the top of
  // the cycle requesting key 'stop_at', otherwise when out_valid first rises.
  task automatic run_rounds(input int stall, input int stop_at, output int latency);
    int idx = 0;
    int sc  = 0;
    latency = 1;
    while (out_valid !== 1'b1) begin
      if (latency > 300 || idx > NR) begin
        check_output("round timeout", out_valid, 1);
        key_valid = 1'b0;
        return;
      end
      if (idx == stop_at) begin
        key_valid = 1'b0;
        return;
      end
      check_output("key_req_valid", key_req_valid, 1);
      check_output("key_req_round", key_req_round, idx);
      check_output("dp_final",      dp_final,      (idx == NR) ? 1 : 0);
      check_output("busy in round", busy,          1);
      key_in = rk[idx];
      if (sc < stall) begin
        key_valid = 1'b0;
        sc++;
      end else begin
        key_valid = 1'b1;
        sc = 0;
        idx++;
      end
      tick();
      latency++;
    end
    key_valid = 1'b0;
    check_output("key beat count", idx, NR + 1);
  endtask

  task automatic apply_stimulus(input aes_block_t pt, input int stall, input int stop_at,
                                output int latency);
    check_output("in_ready before accept", in_ready, 1);
    in_block = pt;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    run_rounds(stall, stop_at, latency);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_block  = '0;
    key_valid = 1'b0;
    key_in    = '0;
    out_ready = 1'b0;
`ifdef AES_ROUND_CTRL_ABORT_EN
    abort     = 1'b0;
`endif
    #2;
    check_reset_values("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] FIPS-197 App. B, key_valid tied high");
    expand_key(KEY_B);
    out_ready = 1'b1;
    apply_stimulus(PT_B, 0, -1, lat);
    check_output("latency no stall", lat, 12);
    check_output("ciphertext B", out_block, CT_B);
    check_output("in_ready in DONE", in_ready, 0);
    tick();
    check_output("idle after handshake", busy, 0);
    check_output("in_ready after handshake", in_ready, 1);

    $display("[TB] key stalls and output backpressure");
    out_ready = 1'b0;
    apply_stimulus(PT_B, 3, -1, lat);
    check_output("latency stalled", lat, 45);
    expand_key(KEY_C);
    in_block = PT_C;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_output("out_valid held", out_valid, 1);
      check_output("out_block held", out_block, CT_B);
      check_output("in_ready low in DONE", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    check_output("out_valid at handshake", out_valid, 1);
    tick();
    check_output("out_valid after handshake", out_valid, 0);
    check_output("in_ready after bp handshake", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check_output("accepted after handshake", busy, 1);
    check_output("state loaded", dp_state, PT_C);
    run_rounds(0, -1, lat);
    check_output("latency C", lat, 12);
    check_output("ciphertext C", out_block, CT_C);
    tick();

    $display("[TB] reset at round 5");
    expand_key(KEY_B);
    apply_stimulus(PT_B, 0, 5, lat);
    check_output("round 5 reached", key_req_round, 5);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid reset");
    tick();
    rst_n = 1'b1;
    tick();
    apply_stimulus(PT_B, 0, -1, lat);
    check_output("latency after reset", lat, 12);
    check_output("ciphertext after reset", out_block, CT_B);
    tick();

`ifdef AES_ROUND_CTRL_ABORT_EN
    $display("[TB] abort at round 3 and in IDLE");
    apply_stimulus(PT_B, 0, 3, lat);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_output("abort out_valid", out_valid, 0);
    check_output("abort in_ready", in_ready, 1);
    check_output("abort busy", busy, 0);
    check_output("abort state cleared", dp_state, 0);
    abort = 1'b1;
    tick();
    check_output("idle abort in_ready", in_ready, 1);
    in_block = PT_B;
    in_valid = 1'b1;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    check_output("accept despite idle abort", busy, 1);
    check_output("state after idle abort", dp_state, PT_B);
    run_rounds(0, -1, lat);
    check_output("latency after abort", lat, 12);
    check_output("ciphertext after abort", out_block, CT_B);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
